id_hazard_scoreboard: RTL and testbench
=======================================

Name: id_hazard_scoreboard

Overview:
- Parametrised successor to the ID-stage forwarding/stall logic for the dynamic pipeline.
- Keeps a per-register pending-write scoreboard: one entry per GPR plus one shared HI/LO entry. Each entry has an age counter and a ready-latency counter.
- From the scoreboard it produces stall, issue and per-operand forward-stage selects.
- Supports an arbitrary forwarding depth and variable producer latencies (ALU, load, multi-cycle mul/div). Sits in ID and drives the ID operand muxes and the IF/ID hold logic.

Parameters:
- NUM_REGS, 32, number of GPRs; entry 0 is never tracked.
- AW, 5, register address width (log2 NUM_REGS).
- DEPTH, 3, number of post-ID stages a result can be forwarded from (1=EXE, 2=MEM, 3=WB).
- SEL_W, 2, width of forward selects; must hold the value DEPTH.
- LAT_W, 4, width of latency fields and ready counters.

Ports:
- clk in 1: clock, rising edge.
- rst in 1: asynchronous, active-low reset.
- id_valid in 1: a valid instruction is present in ID.
- flush in 1: kill the ID instruction this cycle.
- id_rs in AW: rs read address.
- id_rs_ren in 1: rs is read.
- id_rt in AW: rt read address.
- id_rt_ren in 1: rt is read.
- id_rd in AW: destination address.
- id_rd_wen in 1: instruction writes a GPR.
- id_rd_lat in LAT_W: cycles after issue before the GPR result is forwardable.
- id_hilo_ren in 1: instruction reads HI/LO.
- id_hilo_wen in 1: instruction writes HI/LO.
- id_hilo_lat in LAT_W: HI/LO result latency.
- issue out 1: the ID instruction advances this cycle.
- stall out 1: hold PC and IF/ID; insert a bubble into EXE.
- rs_fwd_sel out SEL_W: 0 = regfile, k = stage k.
- rt_fwd_sel out SEL_W: same encoding for rt.
- hilo_fwd_sel out SEL_W: same encoding for HI/LO.
- stall_count out 32: performance counter of stall cycles.

Behaviour:
- Entry state per tracked register r (1..NUM_REGS-1) and for HI/LO:
  - age[r] in 0..DEPTH; 0 = nothing pending.
  - rdy[r] in 0..2^LAT_W-1.
- Reset (rst=0, asynchronous): all age and rdy cleared to 0, stall_count cleared to 0. Consequently stall=0, issue=0 and all fwd_sel=0.
- Hazard detection is combinational on the current (pre-update) state:
  - hz_rs = id_rs_ren & id_rs!=0 & age[id_rs]!=0 & rdy[id_rs]!=0. hz_rt is defined the same way.
  - hz_hilo_r = id_hilo_ren & age[HL]!=0 & rdy[HL]!=0.
  - hz_hilo_w = id_hilo_wen & rdy[HL]!=0. This is a structural stall: there is a single multi-cycle unit.
  - stall = id_valid & ~flush & (hz_rs | hz_rt | hz_hilo_r | hz_hilo_w).
  - issue = id_valid & ~flush & ~stall.
- Forward selects are combinational:
  - rs_fwd_sel = (id_rs_ren & id_rs!=0) ? age[id_rs] : 0. rt_fwd_sel and hilo_fwd_sel follow the same rule.
  - Selects are meaningful only when stall=0.
- Per-cycle update for every entry not being written by an issuing instruction:
  - if age!=0: age <= (age==DEPTH) ? 0 : age+1. Reaching DEPTH+1 means the value is now in the regfile.
  - rdy <= (rdy==0) ? 0 : rdy-1.
- On issue & id_rd_wen & id_rd!=0: age[id_rd] <= 1 and rdy[id_rd] <= min(id_rd_lat, DEPTH-1).
  - The youngest writer overwrites the entry (WAW).
  - Writes to r0 are ignored.
- On issue & id_hilo_wen: age[HL] <= 1 and rdy[HL] <= min(id_hilo_lat, DEPTH-1).
- Latency convention:
  - lat 0 (ALU) is forwardable from EXE in the next cycle.
  - lat 1 (load) costs one stall, then forwards from MEM.
- Simultaneous read and write of the same register by one instruction: the read sees the prior producer; the update applies at the clock edge.
- While stalled or flushed, no entry is written but all entries keep aging. This is what makes a stall resolve.
- stall_count increments by 1 each cycle stall=1 and saturates at 0xFFFFFFFF.
- Reset asserted mid-stall clears everything immediately; stall drops in the same cycle.

Test Plan:
- Back-to-back ALU dependency. Issue add r3 (lat 0), next cycle read r3 -> stall=0, rs_fwd_sel=1; one cycle later read r3 -> rs_fwd_sel=2.
- Load-use. Issue lw r5 (lat 1), next cycle read rt=r5 -> stall=1 for exactly 1 cycle, then rt_fwd_sel=2; stall_count=1.
- Retirement. Issue a write to r7, then 3 idle cycles -> a read of r7 gives rs_fwd_sel=0; after 4 cycles age[r7]=0.
- HI/LO multi-cycle. DEPTH=8 build, mult with id_hilo_lat=5, followed by mflo -> stall for 5 cycles, then hilo_fwd_sel=6. A second mult issued behind it also stalls until rdy[HL]=0.
- r0 and flush:
  - Write to r0, then read r0 -> stall=0, fwd_sel=0.
  - flush=1 with id_valid=1 and hazard -> stall=0, issue=0, no entry written.
- Async reset. Assert rst=0 mid-way through a stalled load-use -> stall, issue, all selects and stall_count are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/id_hazard_scoreboard.sv
// ID-stage pending-write scoreboard: tracks age and ready-latency per GPR plus
// a shared HI/LO entry, and derives stall, issue and operand forward selects.

module id_hs_entry #(
    parameter int DEPTH = 3,
    parameter int SEL_W = 2,
    parameter int LAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_i,
    input  logic [LAT_W-1:0] lat_i,
    output logic [SEL_W-1:0] age_o,
    output logic [LAT_W-1:0] rdy_o
);
    localparam logic [SEL_W-1:0] DEP_S = SEL_W'(DEPTH);

    logic [SEL_W-1:0] age_q, age_d;
    logic [LAT_W-1:0] rdy_q, rdy_d;

    always_comb begin
        age_d = age_q;
        rdy_d = rdy_q;
        if (wr_i) begin
            age_d = SEL_W'(1);
            rdy_d = lat_i;
        end else begin
            // age past DEPTH means the value has landed in the regfile
            if (age_q != '0) age_d = (age_q == DEP_S) ? '0 : age_q + 1'b1;
            if (rdy_q != '0) rdy_d = rdy_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            age_q <= '0;
            rdy_q <= '0;
        end else begin
            age_q <= age_d;
            rdy_q <= rdy_d;
        end
    end

    assign age_o = age_q;
    assign rdy_o = rdy_q;
endmodule

module id_hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int AW       = 5,
    parameter int DEPTH    = 3,
    parameter int SEL_W    = 2,
    parameter int LAT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             flush,
    input  logic [AW-1:0]    id_rs,
    input  logic             id_rs_ren,
    input  logic [AW-1:0]    id_rt,
    input  logic             id_rt_ren,
    input  logic [AW-1:0]    id_rd,
    input  logic             id_rd_wen,
    input  logic [LAT_W-1:0] id_rd_lat,
    input  logic             id_hilo_ren,
    input  logic             id_hilo_wen,
    input  logic [LAT_W-1:0] id_hilo_lat,
    output logic             issue,
    output logic             stall,
    output logic [SEL_W-1:0] rs_fwd_sel,
    output logic [SEL_W-1:0] rt_fwd_sel,
    output logic [SEL_W-1:0] hilo_fwd_sel,
    output logic [31:0]      stall_count
);
    localparam logic [LAT_W-1:0] LMAX = LAT_W'(DEPTH - 1);

    logic [NUM_REGS-1:0][SEL_W-1:0] age_gpr;
    logic [NUM_REGS-1:0][LAT_W-1:0] rdy_gpr;
    logic [SEL_W-1:0] age_hl;
    logic [LAT_W-1:0] rdy_hl;
    logic [LAT_W-1:0] rd_lat_c, hl_lat_c;
    logic             rs_rd, rt_rd, hz_rs, hz_rt, hz_hl_r, hz_hl_w, go;
    logic [31:0]      stall_count_q, stall_count_d;

    assign rd_lat_c = (id_rd_lat   > LMAX) ? LMAX : id_rd_lat;
    assign hl_lat_c = (id_hilo_lat > LMAX) ? LMAX : id_hilo_lat;

    assign age_gpr[0] = '0;
    assign rdy_gpr[0] = '0;

    genvar r;
    generate
        for (r = 1; r < NUM_REGS; r++) begin : g_gpr
            id_hs_entry #(.DEPTH(DEPTH), .SEL_W(SEL_W), .LAT_W(LAT_W)) u_ent (
                .clk   (clk),
                .rst   (rst),
                .wr_i  (issue && id_rd_wen && (id_rd == AW'(r))),
                .lat_i (rd_lat_c),
                .age_o (age_gpr[r]),
                .rdy_o (rdy_gpr[r])
            );
        end
    endgenerate

    id_hs_entry #(.DEPTH(DEPTH), .SEL_W(SEL_W), .LAT_W(LAT_W)) u_hl (
        .clk   (clk),
        .rst   (rst),
        .wr_i  (issue && id_hilo_wen),
        .lat_i (hl_lat_c),
        .age_o (age_hl),
        .rdy_o (rdy_hl)
    );

    assign rs_rd   = id_rs_ren && (id_rs != '0);
    assign rt_rd   = id_rt_ren && (id_rt != '0);
    assign hz_rs   = rs_rd && (age_gpr[id_rs] != '0) && (rdy_gpr[id_rs] != '0);
    assign hz_rt   = rt_rd && (age_gpr[id_rt] != '0) && (rdy_gpr[id_rt] != '0);
    assign hz_hl_r = id_hilo_ren && (age_hl != '0) && (rdy_hl != '0);
    // single multi-cycle unit: a new HI/LO writer waits for the busy one
    assign hz_hl_w = id_hilo_wen && (rdy_hl != '0);

    // gated by rst so both drop the moment reset asserts
    assign go    = rst && id_valid && !flush;
    assign stall = go && (hz_rs || hz_rt || hz_hl_r || hz_hl_w);
    assign issue = go && !stall;

    assign rs_fwd_sel   = rs_rd ? age_gpr[id_rs] : '0;
    assign rt_fwd_sel   = rt_rd ? age_gpr[id_rt] : '0;
    assign hilo_fwd_sel = id_hilo_ren ? age_hl : '0;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 32'hFFFF_FFFF)) stall_count_d = stall_count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_count_q <= '0;
        else      stall_count_q <= stall_count_d;
    end

    assign stall_count = stall_count_q;
endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed bench for id_hazard_scoreboard: DEPTH=3 instance for GPR cases,
// DEPTH=8 instance for the multi-cycle HI/LO case; both share the stimulus.

module tb_id_hazard_scoreboard;
    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, flush, id_rs_ren, id_rt_ren, id_rd_wen, id_hilo_ren, id_hilo_wen;
    logic [4:0] id_rs, id_rt, id_rd;
    logic [3:0] id_rd_lat, id_hilo_lat;

    logic        a_issue, a_stall;
    logic [1:0]  a_rs_sel, a_rt_sel, a_hl_sel;
    logic [31:0] a_cnt;
    logic        b_issue, b_stall;
    logic [3:0]  b_rs_sel, b_rt_sel, b_hl_sel;
    logic [31:0] b_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_hazard_scoreboard #(.NUM_REGS(32), .AW(5), .DEPTH(3), .SEL_W(2), .LAT_W(4)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .flush(flush),
        .id_rs(id_rs), .id_rs_ren(id_rs_ren), .id_rt(id_rt), .id_rt_ren(id_rt_ren),
        .id_rd(id_rd), .id_rd_wen(id_rd_wen), .id_rd_lat(id_rd_lat),
        .id_hilo_ren(id_hilo_ren), .id_hilo_wen(id_hilo_wen), .id_hilo_lat(id_hilo_lat),
        .issue(a_issue), .stall(a_stall), .rs_fwd_sel(a_rs_sel), .rt_fwd_sel(a_rt_sel),
        .hilo_fwd_sel(a_hl_sel), .stall_count(a_cnt)
    );

    id_hazard_scoreboard #(.NUM_REGS(32), .AW(5), .DEPTH(8), .SEL_W(4), .LAT_W(4)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .flush(flush),
        .id_rs(id_rs), .id_rs_ren(id_rs_ren), .id_rt(id_rt), .id_rt_ren(id_rt_ren),
        .id_rd(id_rd), .id_rd_wen(id_rd_wen), .id_rd_lat(id_rd_lat),
        .id_hilo_ren(id_hilo_ren), .id_hilo_wen(id_hilo_wen), .id_hilo_lat(id_hilo_lat),
        .issue(b_issue), .stall(b_stall), .rs_fwd_sel(b_rs_sel), .rt_fwd_sel(b_rt_sel),
        .hilo_fwd_sel(b_hl_sel), .stall_count(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; flush = 0;
        id_rs = 0; id_rs_ren = 0; id_rt = 0; id_rt_ren = 0;
        id_rd = 0; id_rd_wen = 0; id_rd_lat = 0;
        id_hilo_ren = 0; id_hilo_wen = 0; id_hilo_lat = 0;
    endtask

    task automatic wr(input logic [4:0] rd, input logic [3:0] lat);
        idle(); id_valid = 1; id_rd = rd; id_rd_wen = 1; id_rd_lat = lat;
    endtask

    task automatic rd_rs(input logic [4:0] rs);
        idle(); id_valid = 1; id_rs = rs; id_rs_ren = 1;
    endtask

    task automatic rd_rt(input logic [4:0] rt);
        idle(); id_valid = 1; id_rt = rt; id_rt_ren = 1;
    endtask

    // inputs change 1 after posedge, checks happen at negedge
    task automatic nxt();
        @(posedge clk); #1;
    endtask

    initial begin
        idle();
        rst = 0;
        id_valid = 1;
        #2;
        @(negedge clk);
        chk("rst_stall", a_stall, 0);
        chk("rst_issue", a_issue, 0);
        chk("rst_rs_sel", a_rs_sel, 0);
        chk("rst_cnt", a_cnt, 0);
        nxt(); rst = 1; idle();

        // ALU back-to-back
        wr(5'd3, 4'd0);
        @(negedge clk); chk("alu_issue", a_issue, 1);
        nxt(); rd_rs(5'd3);
        @(negedge clk); chk("alu_stall", a_stall, 0); chk("alu_sel1", a_rs_sel, 1);
        nxt(); rd_rs(5'd3);
        @(negedge clk); chk("alu_sel2", a_rs_sel, 2);

        // load-use
        nxt(); wr(5'd5, 4'd1);
        nxt(); rd_rt(5'd5);
        @(negedge clk); chk("lu_stall", a_stall, 1); chk("lu_issue", a_issue, 0);
        nxt();
        @(negedge clk); chk("lu_stall_end", a_stall, 0); chk("lu_rt_sel", a_rt_sel, 2);
        chk("lu_cnt", a_cnt, 1);

        // retirement
        nxt(); wr(5'd7, 4'd0);
        nxt(); idle(); id_rs = 7; id_rs_ren = 1;
        @(negedge clk); chk("ret_age1", a_rs_sel, 1);
        nxt(); @(negedge clk); chk("ret_age2", a_rs_sel, 2);
        nxt(); @(negedge clk); chk("ret_age3", a_rs_sel, 3);
        nxt(); @(negedge clk); chk("ret_age0", a_rs_sel, 0);

        // r0 never tracked
        nxt(); wr(5'd0, 4'd3);
        nxt(); idle(); id_valid = 1; id_rs_ren = 1; id_rt_ren = 1;
        @(negedge clk); chk("r0_stall", a_stall, 0); chk("r0_rs_sel", a_rs_sel, 0);
        chk("r0_rt_sel", a_rt_sel, 0);

        // flush kills a hazarding instruction and writes nothing
        nxt(); wr(5'd9, 4'd1);
        nxt(); wr(5'd10, 4'd0); id_rs = 9; id_rs_ren = 1; flush = 1;
        @(negedge clk); chk("fl_stall", a_stall, 0); chk("fl_issue", a_issue, 0);
        nxt(); rd_rs(5'd10); id_rt = 9; id_rt_ren = 1;
        @(negedge clk); chk("fl_nowrite", a_rs_sel, 0); chk("fl_aged", a_rt_sel, 2);
        chk("fl_nostall", a_stall, 0);

        // async reset mid load-use stall
        nxt(); wr(5'd6, 4'd1);
        nxt(); rd_rs(5'd6);
        @(negedge clk); chk("ar_pre_stall", a_stall, 1); chk("ar_pre_cnt", a_cnt, 1);
        #1 rst = 0;
        #1;
        chk("ar_stall", a_stall, 0);
        chk("ar_issue", a_issue, 0);
        chk("ar_rs_sel", a_rs_sel, 0);
        chk("ar_cnt", a_cnt, 0);
        nxt(); rst = 1; idle();

        // HI/LO multi-cycle on the DEPTH=8 build
        id_valid = 1; id_hilo_wen = 1; id_hilo_lat = 5;
        @(negedge clk); chk("hl_mult_issue", b_issue, 1);
        nxt(); idle(); id_valid = 1; id_hilo_ren = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); chk($sformatf("hl_mflo_stall%0d", i), b_stall, 1);
            nxt();
        end
        @(negedge clk); chk("hl_mflo_go", b_stall, 0); chk("hl_sel", b_hl_sel, 6);
        nxt(); idle(); id_valid = 1; id_hilo_wen = 1; id_hilo_lat = 5;
        @(negedge clk); chk("hl_m1_issue", b_issue, 1);
        nxt();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); chk($sformatf("hl_m2_stall%0d", i), b_stall, 1);
            nxt();
        end
        @(negedge clk); chk("hl_m2_issue", b_issue, 1); chk("hl_cnt", b_cnt, 10);
        nxt(); idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
